// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N-channel push-button synchroniser, debouncer, press/release pulser and auto-repeat
// Optional build macro: BUTTON_ACTIVE_LOW_EN (pins pull low when pressed)
module button_conditioner #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 4000000,
    parameter int REPEAT_PERIOD   = 1250000,
    parameter int CNT_W           = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] butt_raw,
    input  logic [N_BUTTONS-1:0] repeat_mask,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic                 any_press
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    // Terminal counts: a level is accepted once the mismatch has been seen on
    // DEBOUNCE_CYCLES+1 consecutive edges, which puts the pressed edge exactly
    // 2 + DEBOUNCE_CYCLES edges after the pin level is first sampled. The
    // repeat counters likewise fire one edge after reaching their terminal.
    localparam logic [CNT_W-1:0] DB_TERM     = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_TERM  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_TERM = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef BUTTON_ACTIVE_LOW_EN
    // Sync flops carry the raw pin level; idle-high pins must read as released after reset.
    localparam logic SYNC_RST = 1'b1;
`else
    localparam logic SYNC_RST = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
            logic             sync1;
            logic             sync2;
            logic             level;
            logic             flip;
            logic             pressed_q;
            logic             press_q;
            logic             release_q;
            logic [CNT_W-1:0] db;
            logic [CNT_W-1:0] rc;
            rep_state_t       state;

            // Two-flop synchroniser for the asynchronous pin.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1 <= SYNC_RST;
                    sync2 <= SYNC_RST;
                end else begin
                    sync1 <= butt_raw[gi];
                    sync2 <= sync1;
                end
            end

            // Polarity-corrected level and the debounce acceptance strobe.
            always_comb begin
`ifdef BUTTON_ACTIVE_LOW_EN
                level = ~sync2;
`else
                level = sync2;
`endif
                flip = (level != pressed_q) && (db == DB_TERM);
            end

            // Debounce, edge pulses and repeat FSM share one block so a release always beats a coincident repeat.
            always_ff @(posedge clk) begin
                if (reset) begin
                    db        <= '0;
                    rc        <= '0;
                    pressed_q <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                    state     <= ST_IDLE;
                end else begin
                    press_q   <= 1'b0;
                    release_q <= 1'b0;

                    if (level == pressed_q || flip) begin
                        db <= '0;
                    end else if (db != CNT_MAX) begin
                        db <= db + CNT_ONE;
                    end

                    if (flip) begin
                        pressed_q <= ~pressed_q;
                        rc        <= '0;
                        if (!pressed_q) begin
                            press_q <= 1'b1;
                            state   <= ST_DELAY;
                        end else begin
                            release_q <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        case (state)
                            ST_DELAY: begin
                                if (!repeat_mask[gi]) begin
                                    rc <= '0;
                                end else if (rc == DELAY_TERM) begin
                                    press_q <= 1'b1;
                                    state   <= ST_REPEAT;
                                    rc      <= '0;
                                end else if (rc != CNT_MAX) begin
                                    rc <= rc + CNT_ONE;
                                end
                            end
                            ST_REPEAT: begin
                                if (!repeat_mask[gi]) begin
                                    rc <= '0;
                                end else if (rc == PERIOD_TERM) begin
                                    press_q <= 1'b1;
                                    rc      <= '0;
                                end else if (rc != CNT_MAX) begin
                                    rc <= rc + CNT_ONE;
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                                rc    <= '0;
                            end
                        endcase
                    end
                end
            end

            assign pressed[gi]       = pressed_q;
            assign press_pulse[gi]   = press_q;
            assign release_pulse[gi] = release_q;
        end
    endgenerate

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] butt_raw = '0;
    logic [N-1:0] repeat_mask = '0;
    logic [N-1:0] pressed;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         any_press;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .butt_raw     (butt_raw),
        .repeat_mask  (repeat_mask),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_press    (any_press)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a 2-deep sample delay, a run length of disagreeing
    // samples, and a count of enabled held cycles since the last pulse.
    bit [N-1:0] m_pressed, m_pp, m_rp;
    bit         m_any;
    bit         h1[N], h2[N];
    int         run[N], cnt[N], phase[N];
    bit         s_old, rose, fell;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            m_pp[i] = 1'b0;
            m_rp[i] = 1'b0;
            if (reset) begin
                h1[i] = 1'b0; h2[i] = 1'b0; m_pressed[i] = 1'b0;
                run[i] = 0; cnt[i] = 0; phase[i] = 0;
            end else begin
                s_old = h2[i];
                h2[i] = h1[i];
                h1[i] = butt_raw[i];
                rose = 1'b0;
                fell = 1'b0;
                if (s_old != m_pressed[i]) begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        run[i] = 0;
                        m_pressed[i] = ~m_pressed[i];
                        rose = m_pressed[i];
                        fell = ~m_pressed[i];
                    end
                end else begin
                    run[i] = 0;
                end
                if (rose) begin
                    m_pp[i] = 1'b1; phase[i] = 0; cnt[i] = 0;
                end else if (fell) begin
                    m_rp[i] = 1'b1;
                end else if (m_pressed[i]) begin
                    if (repeat_mask[i]) begin
                        cnt[i]++;
                        if (cnt[i] == ((phase[i] != 0) ? RP + 1 : RD + 1)) begin
                            m_pp[i] = 1'b1; phase[i] = 1; cnt[i] = 0;
                        end
                    end else begin
                        cnt[i] = 0;
                    end
                end
            end
        end
        m_any = |m_pp;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pressed", 32'(pressed), 32'(m_pressed));
            check("model_press_pulse", 32'(press_pulse), 32'(m_pp));
            check("model_release_pulse", 32'(release_pulse), 32'(m_rp));
            check("model_any_press", 32'(any_press), 32'(m_any));
        end
    end

    typedef struct {
        logic [N-1:0] chans;
        int           len;
        int           press_off;
        int           rel_off;
    } vec_t;

    vec_t         vecs[5];
    logic [N-1:0] acc;
    int           pcount;
    int           hold[N];

    initial begin
        vecs[0] = '{4'b0001, 20, 7, 27};
        vecs[1] = '{4'b0010, 3, -1, -1};
        vecs[2] = '{4'b0010, 4, -1, -1};
        vecs[3] = '{4'b0010, 5, 7, 12};
        vecs[4] = '{4'b0101, 12, 7, 19};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_pressed", 32'(pressed), 0);
        check("reset_press_pulse", 32'(press_pulse), 0);
        check("reset_release_pulse", 32'(release_pulse), 0);
        check("reset_any_press", 32'(any_press), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Clean presses, glitches and simultaneous presses from the table.
        foreach (vecs[v]) begin
            butt_raw = vecs[v].chans;
            repeat_mask = '0;
            acc = '0;
            for (int c = 1; c <= vecs[v].len + 16; c++) begin
                @(negedge clk);
                if (c == vecs[v].len) butt_raw = '0;
                if (vecs[v].press_off > 0) begin
                    if (c == vecs[v].press_off - 1) check("vec_pressed_early", 32'(pressed), 0);
                    if (c == vecs[v].press_off) begin
                        check("vec_pressed_rise", 32'(pressed), 32'(vecs[v].chans));
                        check("vec_press_pulse", 32'(press_pulse), 32'(vecs[v].chans));
                        check("vec_any_press", 32'(any_press), 1);
                    end
                    if (c == vecs[v].press_off + 1) begin
                        check("vec_press_pulse_width", 32'(press_pulse), 0);
                        check("vec_any_press_width", 32'(any_press), 0);
                    end
                    if (c == vecs[v].rel_off) check("vec_release_pulse", 32'(release_pulse), 32'(vecs[v].chans));
                    if (c == vecs[v].rel_off + 1) check("vec_release_width", 32'(release_pulse), 0);
                end
                acc |= pressed | press_pulse | release_pulse;
            end
            if (vecs[v].press_off < 0) check("glitch_quiet", 32'(acc), 0);
        end

        // Auto-repeat on channel 2; release coincides with the would-be repeat at 38.
        butt_raw = 4'b0100;
        repeat_mask = 4'b0100;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            if (c == 31) butt_raw = '0;
            check("rep_press_pulse2", 32'(press_pulse[2]),
                  32'(c == 7 || c == 18 || c == 22 || c == 26 || c == 30 || c == 34));
            check("rep_release_pulse2", 32'(release_pulse[2]), 32'(c == 38));
        end
        repeat_mask = '0;

        // Mask off on channel 3 for 50 cycles, then re-enable.
        butt_raw = 4'b1000;
        pcount = 0;
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            if (c <= 50 && press_pulse[3]) pcount++;
            if (c == 7) check("mask_first_pulse", 32'(press_pulse[3]), 1);
            if (c == 50) begin
                check("mask_single_pulse", 32'(pcount), 1);
                repeat_mask = 4'b1000;
            end
            if (c > 50) check("mask_resume_pulse", 32'(press_pulse[3]), 32'(c == 61 || c == 65));
        end
        butt_raw = '0;
        repeat_mask = '0;
        repeat (15) @(negedge clk);

        // Reset while channel 0 is repeating.
        butt_raw = 4'b0001;
        repeat_mask = 4'b0001;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 25) reset = 1'b1;
            if (c == 26) begin
                reset = 1'b0;
                check("rst_mid_outputs", 32'({pressed, press_pulse, release_pulse, any_press}), 0);
            end
            check("rst_mid_press_pulse0", 32'(press_pulse[0]),
                  32'(c == 7 || c == 18 || c == 22 || c == 33 || c == 44));
        end
        butt_raw = '0;
        repeat_mask = '0;
        repeat (15) @(negedge clk);

        // Randomised holds, masks and occasional resets against the model.
        foreach (hold[i]) hold[i] = $urandom_range(1, 30);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    butt_raw[i] = ~butt_raw[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 40);
                end
                if ($urandom_range(0, 31) == 0) repeat_mask[i] = ~repeat_mask[i];
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
